// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared state type, default sizes and master indices for the RAM arbiter.
package onchip_mem_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 4096;
  localparam int M0 = 0;
  localparam int M1 = 1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; on contention the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);
  logic last_q;
  always_comb begin
    grant = '0;
    if (enable) grant = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= 1'b1;
    else if (|grant) last_q <= grant[1];
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin sharing of a single-port RAM between two Avalon-MM masters,
// with a clear engine that zero-fills the RAM while holding both masters off.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e        state_q, state_d;
  logic [CW-1:0] clr_addr_q, clr_addr_d;
  logic          rd_pend_q, rd_owner_q, clr_done_q;
  logic [1:0]    req, grant;
  logic          win, clearing, clr_last, rd_issue;
  assign req = {m1_read | m1_write, m0_read | m0_write};
  // clr_start takes the RAM that cycle, so arbitration is suppressed alongside CLEAR
  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .enable (state_q == IDLE && !clr_start),
    .grant  (grant)
  );
  assign win      = grant[M1];
  assign clearing = state_q == CLEAR;
  assign clr_last = clr_addr_q == CW'(DEPTH - 1);
  assign rd_issue = |grant && (win ? (m1_read && !m1_write) : (m0_read && !m0_write));
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (!clearing) begin
      if (clr_start) begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    end else begin
      clr_addr_d = clr_addr_q + CW'(1);
      if (clr_last) state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_pend_q  <= rd_issue;
      rd_owner_q <= rd_issue ? win : rd_owner_q;
      clr_done_q <= clearing && clr_last;
    end
  assign mem_clken      = 1'b1;
  assign mem_chipselect = clearing || |grant;
  assign mem_write      = clearing || (|grant && (win ? m1_write : m0_write));
  assign mem_address    = clearing ? ADDR_W'(clr_addr_q) : (win ? m1_address : m0_address);
  assign mem_byteenable = clearing ? '1 : (win ? m1_byteenable : m0_byteenable);
  assign mem_writedata  = clearing ? '0 : (win ? m1_writedata : m0_writedata);
  assign m0_waitrequest   = req[M0] && !grant[M0];
  assign m1_waitrequest   = req[M1] && !grant[M1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend_q && rd_owner_q == 1'(M0);
  assign m1_readdatavalid = rd_pend_q && rd_owner_q == 1'(M1);
  assign clr_busy         = clearing;
  assign clr_done         = clr_done_q;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed bench with a behavioural RAM and per-master read-data scoreboards.
module tb_onchip_mem_arbiter;
  logic        clk = 0, reset = 1;
  logic [11:0] m0_address = 0, m1_address = 0;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_writedata = 0, m1_writedata = 0;
  logic [3:0]  m0_byteenable = 0, m1_byteenable = 0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        clr_start = 0, clr_busy, clr_done;
  logic [11:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic [31:0] ram [0:4095];
  logic [31:0] q0[$], q1[$];
  int          n_cmp = 0, n_err = 0;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= ram[mem_address];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m0_readdatavalid) begin
      if (q0.size() == 0) chk("m0_unexpected_valid", 1, 0);
      else chk("m0_rdata", m0_readdata, q0.pop_front());
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) chk("m1_unexpected_valid", 1, 0);
      else chk("m1_rdata", m1_readdata, q1.pop_front());
    end
  end

  task automatic drive(input int m, input logic rd, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic acc(input int m);
    bit ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
    end
    chk("accept_timeout", 32'(ok), 1);
  endtask

  task automatic wr(input int m, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(m, 0, 1, a, d, be);
    acc(m);
    @(posedge clk); #1;
    drive(m, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int m, input logic [11:0] a, input logic [31:0] exp);
    if (m == 0) q0.push_back(exp); else q1.push_back(exp);
    drive(m, 1, 0, a, 0, 4'hF);
    acc(m);
    chk("rdv_early", 32'(m == 0 ? m0_readdatavalid : m1_readdatavalid), 0);
    @(posedge clk); #1;
    drive(m, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rdv_latency", 32'(m == 0 ? m0_readdatavalid : m1_readdatavalid), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = clr_done;
    end
    chk(tag, 32'(seen), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int busy_n, done_n, viol;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_done", 32'(clr_done), 0);
    chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("rst_cs_we", {mem_chipselect, mem_write}, 0);
    chk("rst_clken", 32'(mem_clken), 1);
    @(posedge clk); #1 reset = 0;

    // single master write/read, with the idle master seeing no waitrequest
    drive(0, 0, 1, 12'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("single_wait", {m0_waitrequest, m1_waitrequest}, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    rd(0, 12'h010, 32'hDEADBEEF);
    wr(0, 12'hFFF, 32'h0BADF00D, 4'hF);
    rd(1, 12'hFFF, 32'h0BADF00D);

    // contention; preloads by m1 leave last_grant on m1 so m0 wins first
    wr(1, 12'h001, 32'hA1A1A1A1, 4'hF);
    wr(1, 12'h002, 32'hA2A2A2A2, 4'hF);
    q0.push_back(32'hA1A1A1A1); q0.push_back(32'hA1A1A1A1);
    q1.push_back(32'hA2A2A2A2); q1.push_back(32'hA2A2A2A2);
    drive(0, 1, 0, 12'h001, 0, 4'hF);
    drive(1, 1, 0, 12'h002, 0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("cont_wait_%0d", k), {m0_waitrequest, m1_waitrequest}, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;

    // byte lanes
    wr(0, 12'h005, 32'h11223344, 4'hF);
    wr(0, 12'h005, 32'hAABBCCDD, 4'b0101);
    rd(0, 12'h005, 32'h11BB33DD);

    // full clear with m1 held off
    wr(0, 12'h000, 32'h12345678, 4'hF);
    wr(0, 12'h800, 32'h87654321, 4'hF);
    wr(1, 12'h123, 32'h00C0FFEE, 4'hF);
    q1.push_back(32'h0);
    clr_start = 1;
    drive(1, 1, 0, 12'h123, 0, 4'hF);
    @(posedge clk); #1 clr_start = 0;
    busy_n = 0; done_n = 0; viol = 0;
    chk("clr_busy_start", 32'(clr_busy), 1);
    for (int i = 0; i < 5000 && done_n == 0; i++) begin
      @(negedge clk);
      if (clr_done) done_n++;
      else if (!m1_waitrequest) viol++;
      if (clr_busy) busy_n++;
    end
    chk("clr_done_pulse", 32'(done_n), 1);
    chk("clr_m1_accepted", 32'(m1_waitrequest), 0);
    @(posedge clk); #1 drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("clr_done_one_cycle", 32'(clr_done), 0);
    chk("clr_busy_cycles", busy_n, 4096);
    chk("clr_holdoff", viol, 0);
    @(posedge clk); #1;
    rd(0, 12'h000, 32'h0);
    rd(1, 12'hFFF, 32'h0);
    rd(0, 12'h800, 32'h0);

    // read refused in the clr_start cycle, served after the clear
    wr(0, 12'h020, 32'hCAFE0001, 4'hF);
    q0.push_back(32'h0);
    clr_start = 1;
    drive(0, 1, 0, 12'h020, 0, 4'hF);
    @(negedge clk);
    chk("clr_entry_refuse", 32'(m0_waitrequest), 1);
    @(posedge clk); #1 clr_start = 0;
    acc(0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;

    // read accepted just before clr_start still returns pre-clear data
    wr(0, 12'h020, 32'hCAFE0002, 4'hF);
    q0.push_back(32'hCAFE0002);
    drive(0, 1, 0, 12'h020, 0, 4'hF);
    acc(0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    clr_start = 1;
    @(negedge clk);
    chk("inflight_rdv", 32'(m0_readdatavalid), 1);
    @(posedge clk); #1 clr_start = 0;
    chk("inflight_busy", 32'(clr_busy), 1);
    wait_done("inflight_clr_done");

    // reset at clear cycle 100 leaves 0x064 onward untouched
    wr(0, 12'h000, 32'h01010101, 4'hF);
    wr(0, 12'h063, 32'h63636363, 4'hF);
    wr(0, 12'h064, 32'h64646464, 4'hF);
    wr(0, 12'h800, 32'h55AA55AA, 4'hF);
    clr_start = 1;
    @(posedge clk); #1 clr_start = 0;
    repeat (100) @(posedge clk); #1;
    chk("mid_addr", 32'(mem_address), 32'h064);
    chk("mid_busy", {clr_busy, mem_write}, 2'b11);
    reset = 1; #1;
    chk("async_busy_we", {clr_busy, mem_write, mem_chipselect}, 0);
    chk("async_rdv_done", {m0_readdatavalid, m1_readdatavalid, clr_done}, 0);
    @(posedge clk); #1 reset = 0;
    rd(0, 12'h000, 32'h0);
    rd(0, 12'h063, 32'h0);
    rd(1, 12'h064, 32'h64646464);
    rd(1, 12'h800, 32'h55AA55AA);

    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
